// File: rtl/apb_spi_bridge_if.sv
// APB3 bus bundle for the SPI/RF bridge: master drives the request, slave returns
// ready plus the registered write/read data copies.
interface apb_spi_bridge_if;
  logic        i_PSEL0;
  logic        i_PENABLE;
  logic        i_PWRITE;
  logic [15:0] i_PADDR;
  logic [7:0]  i_PWDATA;
  logic [7:0]  i_PRDATA;
  logic        PREADY;
  logic [7:0]  o_PWDATA;
  logic [7:0]  o_PRDATA;

  modport slave (
    input  i_PSEL0, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PRDATA,
    output PREADY, o_PWDATA, o_PRDATA
  );

  modport master (
    output i_PSEL0, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA, i_PRDATA,
    input  PREADY, o_PWDATA, o_PRDATA
  );
endinterface

// File: rtl/apb_spi_bridge.sv
// APB3 register slave fronting an 8-bit serial transmitter and an RF packet hunter
// that captures a 64-bit frame with three 5-bit sync fields, read out byte by byte.
module apb_spi_bridge #(
  parameter int PKT_W  = 64,
  parameter int SYNC_W = 5
) (
  input  logic               i_PCLK,
  input  logic               i_PRESETn,
  apb_spi_bridge_if.slave    apb,
  input  logic [9:0]         i_BASE_ADDR,
  output logic               o_WR0,
  output logic               o_WR1,
  output logic               o_WR2,
  output logic               o_WR3,
  output logic               o_DR0,
  output logic               o_DR1,
  output logic               o_DR2,
  output logic               o_DR3,
  input  logic               rfin,
  input  logic               sh_en,
  input  logic               RX,
  output logic               pkt_rec,
  output logic               TX_OUT
);

  localparam int MID_HI = 37;

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;
  localparam logic [0:0] RX_HUNT  = 1'b0;
  localparam logic [0:0] RX_HOLD  = 1'b1;

  // ---------------- APB decode ----------------
  logic       hit, wr_acc, rd_acc;
  logic [1:0] idx;
  logic       unused_addr;

  assign hit         = apb.i_PSEL0 && (apb.i_PADDR[15:6] == i_BASE_ADDR) && (apb.i_PADDR[5:4] == 2'b00);
  assign idx         = apb.i_PADDR[3:2];
  assign apb.PREADY  = hit & apb.i_PENABLE;
  assign wr_acc      = apb.PREADY &  apb.i_PWRITE;
  assign rd_acc      = apb.PREADY & ~apb.i_PWRITE;
  assign unused_addr = ^apb.i_PADDR[1:0];

  logic [3:0] wr_stb, rd_stb;
  logic [5:0] cfg;
  logic [7:0] tx_reg, pwdata_q, prdata_q, rd_mux;
  logic       start_q;

  assign {o_WR3, o_WR2, o_WR1, o_WR0} = wr_stb;
  assign {o_DR3, o_DR2, o_DR1, o_DR0} = rd_stb;
  assign apb.o_PWDATA = pwdata_q;
  assign apb.o_PRDATA = prdata_q;

  // ---------------- state shared by TX / RX paths ----------------
  logic [0:0]       tx_state, rx_state;
  logic             busy;
  logic [7:0]       sh;
  logic [2:0]       cnt;
  logic [PKT_W-1:0] pkt_reg, pkt_next, pkt_sh;
  logic [2:0]       byte_ptr;
  logic [7:0]       rx_reg, pkt_byte;
  logic             rx_valid;
  logic             sync_hit;

  assign busy    = (tx_state == TX_SHIFT);
  assign pkt_rec = (rx_state == RX_HOLD);

  always_comb begin
    rd_mux = 8'h00;
    case (idx)
      2'd0:    rd_mux = {busy, pkt_rec, rx_valid, 1'b0, cfg[3:0]};
      2'd1:    rd_mux = rx_reg;
      2'd2:    rd_mux = apb.i_PRDATA;
      default: rd_mux = 8'h00;
    endcase
  end

  // Write side: strobes, config/tx registers, self-clearing START pulse
  always_ff @(posedge i_PCLK) begin
    if (i_PRESETn) begin
      wr_stb   <= '0;
      pwdata_q <= '0;
      cfg      <= '0;
      tx_reg   <= '0;
      start_q  <= 1'b0;
    end else begin
      wr_stb  <= '0;
      start_q <= 1'b0;
      if (wr_acc) begin
        wr_stb[idx] <= 1'b1;
        pwdata_q    <= apb.i_PWDATA;
        case (idx)
          2'd0:    cfg     <= apb.i_PWDATA[5:0];
          2'd1:    tx_reg  <= apb.i_PWDATA;
          2'd3:    start_q <= apb.i_PWDATA[1];
          default: ;
        endcase
      end
    end
  end

  // Read side: read data is held until the next read access
  always_ff @(posedge i_PCLK) begin
    if (i_PRESETn) begin
      rd_stb   <= '0;
      prdata_q <= '0;
    end else begin
      rd_stb <= '0;
      if (rd_acc) begin
        rd_stb[idx] <= 1'b1;
        prdata_q    <= rd_mux;
      end
    end
  end

  // ---------------- async input capture ----------------
  logic [1:0] rf_sync;
  logic [2:0] sh_sync;
  logic       tick, rf_s, bit_flag;

  assign rf_s = rf_sync[1];
  assign tick = sh_sync[1] & ~sh_sync[2];

  always_ff @(posedge i_PCLK) begin
    if (i_PRESETn) begin
      rf_sync  <= '0;
      sh_sync  <= '0;
      bit_flag <= 1'b0;
    end else begin
      rf_sync <= {rf_sync[0], rfin};
      sh_sync <= {sh_sync[1:0], sh_en};
      // A pulse landing on the tick belongs to the next bit period
      if (tick)
        bit_flag <= rf_s;
      else if (rf_s)
        bit_flag <= 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  always_ff @(posedge i_PCLK) begin
    if (i_PRESETn) begin
      tx_state <= TX_IDLE;
      sh       <= '0;
      cnt      <= '0;
      TX_OUT   <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (start_q && !RX) begin
            sh       <= tx_reg;
            cnt      <= '0;
            tx_state <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tick) begin
            TX_OUT <= sh[7];
            sh     <= {sh[6:0], 1'b0};
            cnt    <= cnt + 3'd1;
            if (cnt == 3'd7)
              tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- packet receiver ----------------
  assign pkt_next = {pkt_reg[PKT_W-2:0], bit_flag};
  assign sync_hit = (&pkt_next[PKT_W-1 -: SYNC_W]) &&
                    (&pkt_next[MID_HI -: SYNC_W]) &&
                    (&pkt_next[SYNC_W-1:0]);
  assign pkt_sh   = pkt_reg << {byte_ptr, 3'b000};
  assign pkt_byte = pkt_sh[PKT_W-1 -: 8];

  always_ff @(posedge i_PCLK) begin
    if (i_PRESETn) begin
      rx_state <= RX_HUNT;
      pkt_reg  <= '0;
      byte_ptr <= '0;
      rx_reg   <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rd_acc && idx == 2'd1)
        rx_valid <= 1'b0;
      case (rx_state)
        RX_HUNT: begin
          if (tick && RX) begin
            pkt_reg <= pkt_next;
            if (sync_hit) begin
              rx_state <= RX_HOLD;
              byte_ptr <= '0;
            end
          end
          if (start_q && RX)
            rx_reg <= '0;
        end
        RX_HOLD: begin
          if (start_q && RX) begin
            rx_reg   <= pkt_byte;
            rx_valid <= 1'b1;
            byte_ptr <= byte_ptr + 3'd1;
            // Last byte handed out: drop the frame and go back to hunting
            if (byte_ptr == 3'd7) begin
              rx_state <= RX_HUNT;
              pkt_reg  <= '0;
            end
          end
        end
        default: rx_state <= RX_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_bridge.sv
// Directed + randomized bench for apb_spi_bridge: APB register access, serial TX
// bitstream, RF packet hunt/readout against a bit-history reference model.
module tb_apb_spi_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_spi_bridge_if bus ();

  logic [9:0] base;
  logic       wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3;
  logic       rfin, sh_en, rx_mode, pkt_rec, tx_out;
  logic [3:0] wr, dr;

  assign wr = {wr3, wr2, wr1, wr0};
  assign dr = {dr3, dr2, dr1, dr0};

  apb_spi_bridge dut (
    .i_PCLK      (clk),
    .i_PRESETn   (rst),
    .apb         (bus),
    .i_BASE_ADDR (base),
    .o_WR0       (wr0),
    .o_WR1       (wr1),
    .o_WR2       (wr2),
    .o_WR3       (wr3),
    .o_DR0       (dr0),
    .o_DR1       (dr1),
    .o_DR2       (dr2),
    .o_DR3       (dr3),
    .rfin        (rfin),
    .sh_en       (sh_en),
    .RX          (rx_mode),
    .pkt_rec     (pkt_rec),
    .TX_OUT      (tx_out)
  );

  int errors = 0;
  int checks = 0;

  // reference state
  logic [5:0]  m_cfg;
  logic        m_busy, m_rec, m_rxv;
  logic [63:0] m_pkt;
  bit          hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input logic hit, output logic [7:0] rdata);
    logic [3:0] exp_wr, exp_dr;
    exp_wr = (hit && w)  ? (4'b0001 << a[3:2]) : 4'b0000;
    exp_dr = (hit && !w) ? (4'b0001 << a[3:2]) : 4'b0000;
    @(negedge clk);
    bus.i_PSEL0 = 1'b1; bus.i_PENABLE = 1'b0; bus.i_PWRITE = w;
    bus.i_PADDR = a;    bus.i_PWDATA = d;
    #1 chk("pready_setup", bus.PREADY, 1'b0);
    @(negedge clk);
    bus.i_PENABLE = 1'b1;
    #1 chk("pready_access", bus.PREADY, hit);
    @(negedge clk);
    chk("wr_strobe", wr, exp_wr);
    chk("rd_strobe", dr, exp_dr);
    rdata = bus.o_PRDATA;
    bus.i_PSEL0 = 1'b0; bus.i_PENABLE = 1'b0;
    @(negedge clk);
    chk("strobe_clear", {dr, wr}, 8'h00);
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] rd;
    apb_xfer(1'b0, 16'h0040, 8'h00, 1'b1, rd);
    chk(tag, rd, {m_busy, m_rec, m_rxv, 1'b0, m_cfg[3:0]});
  endtask

  task automatic tick_pulse();
    @(negedge clk); sh_en = 1'b1;
    repeat (3) @(negedge clk);
    sh_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic poke);
    logic [7:0] rd;
    apb_xfer(1'b1, 16'h0044, b, 1'b1, rd);
    apb_xfer(1'b1, 16'h004C, 8'h02, 1'b1, rd);
    m_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick_pulse();
      chk("tx_bit", tx_out, b[7-i]);
      if (i == 7) m_busy = 1'b0;
      if (i == 3 || i == 7) chk_status("status_busy");
      if (poke && i == 3) begin
        // START while busy must not disturb the byte in flight
        apb_xfer(1'b1, 16'h0044, ~b, 1'b1, rd);
        apb_xfer(1'b1, 16'h004C, 8'h02, 1'b1, rd);
      end
    end
  endtask

  task automatic send_rf_bit(input bit b);
    if (b) begin
      @(negedge clk); rfin = 1'b1;
      repeat (2) @(negedge clk);
      rfin = 1'b0;
    end
    repeat (3) @(negedge clk);
    tick_pulse();
  endtask

  // packet register = last 64 bits received since hunting (re)started
  function automatic logic [63:0] window();
    logic [63:0] p;
    int n;
    p = '0;
    n = hist.size();
    for (int k = 0; k < 64; k++)
      if (n - 1 - k >= 0) p[k] = hist[n-1-k];
    return p;
  endfunction

  function automatic logic frame_ok(input logic [63:0] p);
    return (p[63:59] == 5'h1F) && (p[37:33] == 5'h1F) && (p[4:0] == 5'h1F);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd, ext;
    logic [63:0] tx_word;
    bit          stream[$];

    bus.i_PSEL0 = 1'b0; bus.i_PENABLE = 1'b0; bus.i_PWRITE = 1'b0;
    bus.i_PADDR = '0;   bus.i_PWDATA = '0;    bus.i_PRDATA = '0;
    base = 10'h001; rfin = 1'b0; sh_en = 1'b0; rx_mode = 1'b0;
    m_cfg = '0; m_busy = 1'b0; m_rec = 1'b0; m_rxv = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_pready", bus.PREADY, 1'b0);
    chk("rst_prdata", bus.o_PRDATA, 8'h00);
    chk("rst_pwdata", bus.o_PWDATA, 8'h00);
    chk("rst_strobes", {dr, wr}, 8'h00);
    chk("rst_tx_out", tx_out, 1'b0);
    chk("rst_pkt_rec", pkt_rec, 1'b0);
    chk_status("rst_status");

    // CONFIG write/read
    apb_xfer(1'b1, 16'h0040, 8'h05, 1'b1, rd);
    m_cfg = 6'h05;
    chk("pwdata_copy", bus.o_PWDATA, 8'h05);
    chk_status("cfg_readback");

    // wrong page and wrong sub-block miss
    apb_xfer(1'b1, 16'h0080, 8'hAA, 1'b0, rd);
    apb_xfer(1'b1, 16'h0050, 8'h3A, 1'b0, rd);
    apb_xfer(1'b0, 16'h0084, 8'h00, 1'b0, rd);
    chk("miss_pwdata", bus.o_PWDATA, 8'h05);
    chk_status("miss_cfg_kept");

    // unused CONFIG bits dropped, external and zero read indexes
    apb_xfer(1'b1, 16'h0040, 8'hFA, 1'b1, rd);
    m_cfg = 6'h3A;
    chk_status("cfg_masked");
    ext = 8'($urandom);
    bus.i_PRDATA = ext;
    apb_xfer(1'b0, 16'h0048, 8'h00, 1'b1, rd);
    chk("ext_read", rd, ext);
    apb_xfer(1'b0, 16'h004C, 8'h00, 1'b1, rd);
    chk("idx3_read", rd, 8'h00);
    chk("prdata_hold", bus.o_PRDATA, 8'h00);

    // transmitter
    send_byte(8'h55, 1'b1);
    tx_word = 64'h8123456789ABCD0F;
    for (int k = 0; k < 8; k++) send_byte(tx_word[63-8*k -: 8], 1'b0);
    send_byte(8'($urandom), 1'b0);

    // RF hunt: preamble then three sync fields with random gaps
    rx_mode = 1'b1;
    stream = '{0,0,0,1,0,1,1,1,0,0};
    for (int i = 0; i < 5;  i++) stream.push_back(1'b1);
    for (int i = 0; i < 21; i++) stream.push_back(bit'($urandom_range(0, 1)));
    for (int i = 0; i < 5;  i++) stream.push_back(1'b1);
    for (int i = 0; i < 28; i++) stream.push_back(bit'($urandom_range(0, 1)));
    for (int i = 0; i < 5;  i++) stream.push_back(1'b1);
    hist.delete();
    foreach (stream[i]) begin
      send_rf_bit(stream[i]);
      hist.push_back(stream[i]);
      m_pkt = window();
      if (frame_ok(m_pkt)) m_rec = 1'b1;
      chk("pkt_rec_hunt", pkt_rec, m_rec);
      if (m_rec) break;
    end
    // frozen: further bits are ignored
    send_rf_bit(1'b1);
    send_rf_bit(1'b0);
    chk("pkt_rec_frozen", pkt_rec, 1'b1);
    chk_status("status_rec");

    // readout, MSB byte first
    for (int k = 0; k < 8; k++) begin
      apb_xfer(1'b1, 16'h004C, 8'h02, 1'b1, rd);
      if (k == 7) m_rec = 1'b0;
      m_rxv = 1'b1;
      if (k == 0) chk_status("status_rx_valid");
      apb_xfer(1'b0, 16'h0044, 8'h00, 1'b1, rd);
      m_rxv = 1'b0;
      chk("rx_byte", rd, m_pkt[63-8*k -: 8]);
      chk("pkt_rec_readout", pkt_rec, m_rec);
    end
    chk_status("status_after_readout");
    apb_xfer(1'b1, 16'h004C, 8'h02, 1'b1, rd);
    apb_xfer(1'b0, 16'h0044, 8'h00, 1'b1, rd);
    chk("rx_empty_start", rd, 8'h00);

    // reset in the middle of a transmit
    rx_mode = 1'b0;
    apb_xfer(1'b1, 16'h0044, 8'hC0, 1'b1, rd);
    apb_xfer(1'b1, 16'h004C, 8'h02, 1'b1, rd);
    tick_pulse();
    tick_pulse();
    chk("tx_pre_reset", tx_out, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_cfg = '0; m_busy = 1'b0; m_rec = 1'b0; m_rxv = 1'b0;
    chk("tx_after_reset", tx_out, 1'b0);
    chk("pkt_rec_after_reset", pkt_rec, 1'b0);
    tick_pulse();
    chk("tx_no_resume", tx_out, 1'b0);
    chk_status("status_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
